// File: rtl/dff_q_event_monitor_pkg.sv
// Shared types and default widths for the DFF q/qbar event monitor.
//   evt_kind_e : event kind code carried on evt_kind
//   evt_t      : event record {kind, len, ts} at the default widths
//   edge_kind  : maps the new q level to RISE/FALL
package dff_mon_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int TS_W_DEF       = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        EVT_NONE      = 2'b00,
        EVT_RISE      = 2'b01,
        EVT_FALL      = 2'b10,
        EVT_COMPL_ERR = 2'b11
    } evt_kind_e;

    // Default-width record; the top declares the same layout at its own widths.
    typedef struct packed {
        evt_kind_e             kind;
        logic [CNT_W_DEF-1:0]  len;
        logic [TS_W_DEF-1:0]   ts;
    } evt_t;

    function automatic evt_kind_e edge_kind(input logic q_new);
        return q_new ? EVT_RISE : EVT_FALL;
    endfunction

endpackage

// File: rtl/dff_q_event_monitor_if.sv
// Bundle between the DFF stage / event consumer and the monitor.
//   en, q, qbar       : sample enable and DFF outputs into the monitor
//   evt_valid/ready   : FWFT event stream handshake
//   evt_kind/len/ts   : head event fields
//   overflow          : sticky drop indicator
// slave = monitor side, master = stimulus/consumer side.
interface dff_q_event_monitor_if #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 16
);
    logic             en;
    logic             q;
    logic             qbar;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_kind;
    logic [CNT_W-1:0] evt_len;
    logic [TS_W-1:0]  evt_ts;
    logic             overflow;

    modport master (
        output en, q, qbar, evt_ready,
        input  evt_valid, evt_kind, evt_len, evt_ts, overflow
    );

    modport slave (
        input  en, q, qbar, evt_ready,
        output evt_valid, evt_kind, evt_len, evt_ts, overflow
    );
endinterface

// File: rtl/dff_q_event_monitor_evt_fifo.sv
// First-word-fall-through FIFO for monitor events.
//   clk, rst : clock, synchronous active-high reset (flushes contents)
//   push     : write wdata when not full, or when full and popping this cycle
//   full     : all DEPTH entries occupied
//   pop      : remove head; ignored while empty
//   empty    : no head available
//   rdata    : head entry, held in a register
// DEPTH must be a power of two so the pointers wrap naturally.
module dff_evt_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          valid_reg;
    logic [W-1:0]  head_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = !valid_reg;
    assign rdata   = head_reg;
    assign do_pop  = pop && valid_reg;
    // A pop frees the slot the push needs, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_next = rd_ptr_reg + AW'(do_pop);
        count_next  = count_reg + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= (count_next != '0);
            // When nothing older survives this cycle, the incoming word becomes
            // the head directly; the array copy is not written until this edge.
            if (do_push && (count_reg == CW'(do_pop))) begin
                head_reg <= wdata;
            end else if (count_next != '0) begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end
endmodule

// File: rtl/dff_q_event_monitor.sv
// Monitor for a DFF's q/qbar pair: detects q edges, measures level run
// lengths, flags complement violations and queues events for a consumer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dff_q_event_monitor_if.slave (en/q/qbar in, event stream out)
// Pipeline: inputs captured into q_s/qbar_s at sample edge E0, the event is
// staged in a pending register at E0 and written to the FIFO at E1.
module dff_q_event_monitor
    import dff_mon_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TS_W       = TS_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    dff_q_event_monitor_if.slave   bus
);
    localparam int W = 2 + CNT_W + TS_W;

    typedef struct packed {
        evt_kind_e         kind;
        logic [CNT_W-1:0]  len;
        logic [TS_W-1:0]   ts;
    } mon_evt_t;

    logic             q_s_reg;
    logic             qbar_s_reg;
    logic             primed_reg;
    logic [CNT_W-1:0] run_reg;
    logic [CNT_W-1:0] run_inc;
    logic [TS_W-1:0]  ts_reg;
    logic             pend_valid_reg;
    evt_kind_e        pend_kind_reg;
    logic [CNT_W-1:0] pend_len_reg;
    logic             overflow_reg;

    logic             edge_det;
    logic             compl_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    mon_evt_t         push_evt;
    mon_evt_t         head_evt;
    logic [W-1:0]     head_bits;

    // q_s/qbar_s still hold the previous sample here, so they play the role of
    // q_last while the new sample is being taken. primed gates out the very
    // first sample after reset, which has no valid predecessor.
    assign edge_det    = primed_reg && (bus.q != q_s_reg);
    assign compl_entry = primed_reg && (bus.q == bus.qbar) && (q_s_reg != qbar_s_reg);
    assign run_inc     = (run_reg == {CNT_W{1'b1}}) ? run_reg : run_reg + CNT_W'(1);
    assign fifo_pop    = bus.evt_ready && !fifo_empty;

    always_comb begin
        push_evt      = '0;
        push_evt.kind = pend_kind_reg;
        push_evt.len  = pend_len_reg;
        push_evt.ts   = ts_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_s_reg        <= 1'b0;
            qbar_s_reg     <= 1'b1;
            primed_reg     <= 1'b0;
            run_reg        <= '0;
            ts_reg         <= '0;
            pend_valid_reg <= 1'b0;
            pend_kind_reg  <= EVT_NONE;
            pend_len_reg   <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            ts_reg         <= ts_reg + TS_W'(1);
            pend_valid_reg <= 1'b0;
            if (bus.en) begin
                q_s_reg    <= bus.q;
                qbar_s_reg <= bus.qbar;
                primed_reg <= 1'b1;
                run_reg    <= edge_det ? CNT_W'(1) : run_inc;
                // Complement entry wins over a coincident edge.
                if (compl_entry) begin
                    pend_valid_reg <= 1'b1;
                    pend_kind_reg  <= EVT_COMPL_ERR;
                    pend_len_reg   <= '0;
                end else if (edge_det) begin
                    pend_valid_reg <= 1'b1;
                    pend_kind_reg  <= edge_kind(bus.q);
                    pend_len_reg   <= run_reg;
                end
            end
            if (pend_valid_reg && fifo_full && !fifo_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    dff_evt_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pend_valid_reg),
        .wdata (push_evt),
        .full  (fifo_full),
        .pop   (bus.evt_ready),
        .empty (fifo_empty),
        .rdata (head_bits)
    );

    assign head_evt      = mon_evt_t'(head_bits);
    assign bus.evt_valid = !fifo_empty;
    assign bus.evt_kind  = head_evt.kind;
    assign bus.evt_len   = head_evt.len;
    assign bus.evt_ts    = head_evt.ts;
    assign bus.overflow  = overflow_reg;
endmodule
